// File: rtl/uart_frame_loader.sv
// Parses SYNC / length / payload / checksum frames from a UART byte stream and
// writes the payload as packed 32-bit words to a word-addressed memory port.
module uart_frame_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         ADDR_W         = 14,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [TMR_W-1:0]  r_timer;
  logic [7:0]        r_lenLo;
  logic [7:0]        r_sum;
  logic [15:0]       r_remain;
  logic [31:0]       r_word;
  logic [1:0]        r_bytePos;
  logic              r_ovf;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [31:0]       r_wrData;
  logic              r_wrEn;
  logic              r_frameDone;
  logic              r_frameOk;
  logic [1:0]        r_errCode;

  logic        w_timeout;
  logic        w_lastByte;
  logic        w_flush;
  logic [7:0]  w_sumNext;
  logic [31:0] w_packed;

  // A byte arriving on the expiry cycle beats the timeout.
  assign w_timeout  = (r_state != S_IDLE) && !in_valid &&
                      (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_lastByte = (r_remain == 16'd1);
  assign w_flush    = (r_state == S_PAYLOAD) && in_valid &&
                      ((r_bytePos == 2'd3) || w_lastByte);
  assign w_sumNext  = r_sum + in_data;
  assign w_packed   = r_word | (32'(in_data) << {r_bytePos, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_timeout) begin
      w_stateNext = S_IDLE;
    end else if (in_valid) begin
      unique case (r_state)
        S_IDLE:    if (in_data == SYNC_BYTE) w_stateNext = S_LEN_LO;
        S_LEN_LO:  w_stateNext = S_LEN_HI;
        S_LEN_HI:  w_stateNext = ({in_data, r_lenLo} != 16'd0) ? S_PAYLOAD : S_CSUM;
        S_PAYLOAD: if (w_lastByte) w_stateNext = S_CSUM;
        S_CSUM:    w_stateNext = S_IDLE;
        default:   w_stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_lenLo     <= '0;
      r_sum       <= '0;
      r_remain    <= '0;
      r_word      <= '0;
      r_bytePos   <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_wrEn      <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameOk   <= 1'b0;
      r_errCode   <= 2'b00;
    end else begin
      r_wrEn      <= 1'b0;
      r_frameDone <= 1'b0;
      if (r_wrEn) r_wrAddr <= r_wrAddr + ADDR_W'(1);
      if ((r_state == S_IDLE) || in_valid) r_timer <= '0;
      else                                 r_timer <= r_timer + TMR_W'(1);

      if (w_timeout) begin
        r_frameDone <= 1'b1;
        r_frameOk   <= 1'b0;
        r_errCode   <= 2'b11;
      end else if (in_valid) begin
        case (r_state)
          S_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              r_sum     <= '0;
              r_count   <= '0;
              r_wrAddr  <= '0;
              r_word    <= '0;
              r_bytePos <= '0;
              r_ovf     <= 1'b0;
            end
          end
          S_LEN_LO: begin
            r_lenLo <= in_data;
            r_sum   <= w_sumNext;
          end
          S_LEN_HI: begin
            r_remain <= {in_data, r_lenLo};
            r_sum    <= w_sumNext;
          end
          S_PAYLOAD: begin
            r_sum    <= w_sumNext;
            r_remain <= r_remain - 16'd1;
            if (w_flush) begin
              r_word    <= '0;
              r_bytePos <= '0;
              // Words past the end of memory are dropped but the frame is still parsed.
              if (r_count[ADDR_W]) begin
                r_ovf <= 1'b1;
              end else begin
                r_wrEn   <= 1'b1;
                r_wrData <= w_packed;
                r_wrAddr <= r_count[ADDR_W-1:0];
                r_count  <= r_count + (ADDR_W+1)'(1);
              end
            end else begin
              r_word    <= w_packed;
              r_bytePos <= r_bytePos + 2'd1;
            end
          end
          S_CSUM: begin
            r_frameDone <= 1'b1;
            if (r_ovf) begin
              r_frameOk <= 1'b0;
              r_errCode <= 2'b10;
            end else if (w_sumNext != 8'h00) begin
              r_frameOk <= 1'b0;
              r_errCode <= 2'b01;
            end else begin
              r_frameOk <= 1'b1;
              r_errCode <= 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign frame_done = r_frameDone;
  assign frame_ok   = r_frameOk;
  assign err_code   = r_errCode;
  assign word_count = r_count;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected writes and frame results are
// queued as bytes are driven and checked as the DUT emits them.
module tb_uart_frame_loader;

  localparam int AW  = 2;
  localparam int TMO = 40;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          frame_done;
  logic          frame_ok;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [AW+31:0] wrQ[$];
  logic [AW+3:0]  frQ[$];
  logic [7:0]     txQ[$];
  logic [7:0]     payQ[$];

  uart_frame_loader #(
    .SYNC_BYTE(8'hA5),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .err_code(err_code),
    .word_count(word_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops and compares expected writes / frame results whenever the DUT emits one.
  always @(negedge clk) begin
    logic [AW+31:0] expW;
    logic [AW+3:0]  expF;
    if (wr_en) begin
      checks++;
      if (wrQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        expW = wrQ.pop_front();
        if ({wr_addr, wr_data} !== expW) begin
          failures++;
          $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, expW[AW+31:32], expW[31:0]);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (frQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_done: got ok=%b err=%b count=%0d, required no frame_done",
                 frame_ok, err_code, word_count);
      end else begin
        expF = frQ.pop_front();
        if ({frame_ok, err_code, word_count} !== expF) begin
          failures++;
          $display("[TB] FAIL frame_result: got ok=%b err=%b count=%0d, required ok=%b err=%b count=%0d",
                   frame_ok, err_code, word_count, expF[AW+3], expF[AW+2:AW+1], expF[AW:0]);
        end
      end
    end
  end

  task automatic driveBytes();
    while (txQ.size() != 0) begin
      @(negedge clk);
      in_data  = txQ.pop_front();
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference packing/checksum model: appends a frame built from payQ to txQ.
  task automatic buildFrame(input logic [7:0] csumAdj);
    logic [15:0] len;
    logic [7:0]  sum;
    logic [31:0] word;
    int          nWords;
    logic        ovf;
    len    = 16'(payQ.size());
    sum    = len[7:0] + len[15:8];
    word   = '0;
    nWords = 0;
    ovf    = 1'b0;
    txQ.push_back(8'hA5);
    txQ.push_back(len[7:0]);
    txQ.push_back(len[15:8]);
    for (int i = 0; i < payQ.size(); i++) begin
      sum = sum + payQ[i];
      txQ.push_back(payQ[i]);
      word[8*(i%4) +: 8] = payQ[i];
      if ((i % 4 == 3) || (i == payQ.size() - 1)) begin
        if (nWords < 2**AW) begin
          wrQ.push_back({AW'(nWords), word});
          nWords++;
        end else begin
          ovf = 1'b1;
        end
        word = '0;
      end
    end
    txQ.push_back(8'h00 - sum + csumAdj);
    if (ovf)                frQ.push_back({1'b0, 2'b10, (AW+1)'(nWords)});
    else if (csumAdj != 0)  frQ.push_back({1'b0, 2'b01, (AW+1)'(nWords)});
    else                    frQ.push_back({1'b1, 2'b00, (AW+1)'(nWords)});
    payQ.delete();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((wrQ.size() != 0 || frQ.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wrQ.size() != 0 || frQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d writes and %0d results pending, required 0 and 0",
               name, wrQ.size(), frQ.size());
      wrQ.delete();
      frQ.delete();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, frame_ok, err_code, word_count, busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got wr_en=%b addr=%0d data=%h done=%b ok=%b err=%b count=%0d busy=%b, required all 0",
               wr_en, wr_addr, wr_data, frame_done, frame_ok, err_code, word_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    // Checksum covers the two length bytes as well: 0x08 + 1..8 = 0x2C -> 0xD4.
    wrQ.push_back({2'd0, 32'h04030201});
    wrQ.push_back({2'd1, 32'h08070605});
    frQ.push_back({1'b1, 2'b00, 3'd2});
    txQ = {8'hA5, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08, 8'hD4};
    driveBytes();
    waitDrain("basic");
    checks++;
    if ({frame_ok, err_code, busy} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL basic_hold: got ok=%b err=%b busy=%b, required ok=1 err=00 busy=0",
               frame_ok, err_code, busy);
    end
  endtask

  task automatic test_partial_word();
    wrQ.push_back({2'd0, 32'h44332211});
    wrQ.push_back({2'd1, 32'h00000055});
    frQ.push_back({1'b1, 2'b00, 3'd2});
    txQ = {8'hA5, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFC};
    driveBytes();
    waitDrain("partial");
  endtask

  task automatic test_bad_checksum();
    wrQ.push_back({2'd0, 32'h44332211});
    wrQ.push_back({2'd1, 32'h00000055});
    frQ.push_back({1'b0, 2'b01, 3'd2});
    txQ = {8'hA5, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFD};
    driveBytes();
    waitDrain("badcsum");
    checks++;
    if ({frame_ok, err_code} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL badcsum_hold: got ok=%b err=%b, required ok=0 err=01", frame_ok, err_code);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 20; i++) payQ.push_back(8'(i * 7 + 3));
    // Corrupt checksum too: overflow must still be the reported error.
    buildFrame(8'h01);
    frQ.delete();
    frQ.push_back({1'b0, 2'b10, 3'd4});
    driveBytes();
    waitDrain("overflow");
  endtask

  task automatic test_timeout();
    int  n;
    logic seen;
    frQ.push_back({1'b0, 2'b11, 3'd0});
    txQ = {8'hA5, 8'h03, 8'h00, 8'hAA};
    driveBytes();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TMO + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen || n != TMO) begin
      failures++;
      $display("[TB] FAIL timeout_latency: got seen=%b after %0d cycles, required seen=1 after %0d cycles",
               seen, n, TMO);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_busy: got busy=%b, required 0", busy);
    end
    waitDrain("timeout");
  endtask

  task automatic test_timeout_edge();
    wrQ.push_back({2'd0, 32'h00CCBBAA});
    frQ.push_back({1'b1, 2'b00, 3'd1});
    txQ = {8'hA5, 8'h03, 8'h00, 8'hAA};
    driveBytes();
    repeat (TMO - 2) @(negedge clk);
    txQ = {8'hBB, 8'hCC, 8'hCC};
    driveBytes();
    waitDrain("timeout_edge");
  endtask

  task automatic test_reset_abort();
    txQ = {8'hA5, 8'h08, 8'h00, 8'h01, 8'h02};
    driveBytes();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_busy_before: got busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_en, frame_done, busy, word_count} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_in_reset: got wr_en=%b done=%b busy=%b count=%0d, required all 0",
               wr_en, frame_done, busy, word_count);
    end
    rst_n = 1'b1;
    txQ = {8'h37, 8'h37};
    driveBytes();
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, wr_en, frame_done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL noise_idle: got busy=%b wr_en=%b done=%b, required 0 0 0", busy, wr_en, frame_done);
    end
    waitDrain("abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) payQ.push_back(8'($urandom_range(0, 255)));
    buildFrame(8'h00);
    for (int i = 0; i < 3; i++) payQ.push_back(8'($urandom_range(0, 255)));
    buildFrame(8'h00);
    buildFrame(8'h00);
    for (int i = 0; i < 12; i++) payQ.push_back(8'($urandom_range(0, 255)));
    buildFrame(8'h00);
    driveBytes();
    waitDrain("back_to_back");
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial_word();
    test_bad_checksum();
    test_overflow();
    test_timeout();
    test_timeout_edge();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
